// File: rtl/uart_rx_edge_bit_sampler.sv
// UART receiver timing front end.
// Synchronizes the raw serial line, counts oversample edges within a bit and
// bits within a frame, and majority-votes three mid-bit samples into one data
// bit. The RX control FSM drives enable/dat_samp_en and reads the counters.
module uart_rx_edge_bit_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 5,
    parameter int BIT_W       = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_IN,
    input  logic [5:0]       Prescale,
    input  logic             enable,
    input  logic             dat_samp_en,
    output logic             rx_sync,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             sampled_bit,
    output logic             sample_valid,
    output logic             noise_det,
    output logic             cfg_err
);

    // Common compare width wide enough for both the edge counter and the
    // 6-bit prescale value plus the +1 of the vote position.
    localparam int            CW     = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [CW-1:0] CW_ONE = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [5:0]             presc_q;
    logic                   presc_legal;
    logic [CW-1:0]          edge_ext;
    logic [CW-1:0]          presc_ext;
    logic [CW-1:0]          half;
    logic                   run;
    logic                   last_edge;
    logic                   samp_on;
    logic                   at_s0;
    logic                   at_s1;
    logic                   at_vote;
    logic                   s0;
    logic                   s1;
    logic                   vote;
    logic                   disagree;

    assign rx_sync     = sync_q[SYNC_STAGES-1];
    assign presc_legal = (Prescale == 6'd8) || (Prescale == 6'd16) || (Prescale == 6'd32);

    assign edge_ext  = CW'(edge_cnt);
    assign presc_ext = CW'(presc_q);
    assign half      = presc_ext >> 1;

    // Counters only advance for a legal latched ratio.
    assign run       = enable && !cfg_err;
    assign last_edge = (edge_ext == (presc_ext - CW_ONE));

    // Sample points straddle the bit centre: H-1, H, and the vote at H+1.
    assign samp_on = dat_samp_en && run;
    assign at_s0   = (edge_ext == (half - CW_ONE));
    assign at_s1   = (edge_ext == half);
    assign at_vote = (edge_ext == (half + CW_ONE));

    // The third sample is the live synchronized value at the vote edge.
    assign vote     = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
    assign disagree = !((s0 == s1) && (s1 == rx_sync));

    // Metastability synchronizer for the asynchronous line; idles high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '1;
        end else begin
            // NOTE: non-blocking assignment lets every stage take the value its
            // predecessor held before this edge, which is what forms the chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_IN};
        end
    end

    // Latch the oversampling ratio while idle; it is frozen for the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q <= 6'd16;
            cfg_err <= 1'b0;
        end else if (!enable) begin
            presc_q <= Prescale;
            cfg_err <= !presc_legal;
        end
    end

    // Edge counter wraps each bit period; bit counter saturates at all ones.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!run) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (last_edge) begin
            edge_cnt <= '0;
            if (bit_cnt != '1) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end else begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

    // Capture two mid-bit samples and vote them with the third at H+1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0           <= 1'b1;
            s1           <= 1'b1;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
            noise_det    <= 1'b0;
        end else begin
            // NOTE: the pulse outputs default low every cycle so they are
            // single-cycle strobes and no path leaves them unassigned.
            sample_valid <= 1'b0;
            noise_det    <= 1'b0;
            if (!enable) begin
                // Abandoned bit: drop partial captures, keep the last result.
                s0 <= 1'b1;
                s1 <= 1'b1;
            end else if (samp_on) begin
                if (at_s0) begin
                    s0 <= rx_sync;
                end
                if (at_s1) begin
                    s1 <= rx_sync;
                end
                if (at_vote) begin
                    sampled_bit  <= vote;
                    sample_valid <= 1'b1;
                    noise_det    <= disagree;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// Randomized scoreboard bench for uart_rx_edge_bit_sampler.
// Stimulus tasks push expected counter state per cycle and expected vote
// results per bit; a monitor pops and compares as the DUT produces outputs.
module tb_uart_rx_edge_bit_sampler;

    localparam int S = 2;

    typedef struct {
        logic [4:0] ec;
        logic [3:0] bc;
        logic       cfg;
        logic       rxs;
    } cnt_t;

    typedef struct {
        logic       val;
        logic       noise;
        logic [4:0] ec;
        logic [3:0] bc;
    } smp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd16;
    logic       enable = 1'b0;
    logic       dat_samp_en = 1'b0;
    logic       rx_sync;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_valid;
    logic       noise_det;
    logic       cfg_err;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   hist [0:19999];
    int   cyc = 8;
    bit   mon_on = 1'b0;
    int   m_p = 16;
    bit   m_cfg = 1'b0;
    int   m_k = 0;
    logic last_bit = 1'b1;
    cnt_t cq[$];
    smp_t sq[$];
    cnt_t mc;
    smp_t ms;

    uart_rx_edge_bit_sampler #(.SYNC_STAGES(S), .CNT_W(5), .BIT_W(4)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
        .enable(enable), .dat_samp_en(dat_samp_en), .rx_sync(rx_sync),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .sampled_bit(sampled_bit),
        .sample_valid(sample_valid), .noise_det(noise_det), .cfg_err(cfg_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input int p);
        return (p == 8) || (p == 16) || (p == 32);
    endfunction

    // One clock of stimulus; the expected post-edge counter state follows from
    // the number of enabled cycles since the last idle cycle.
    task automatic step(input bit rx, input bit en, input bit dse, input logic [5:0] ps);
        cnt_t c;
        @(negedge CLK);
        RX_IN = rx;
        enable = en;
        dat_samp_en = dse;
        Prescale = ps;
        hist[cyc] = rx;
        if (!en) begin
            m_p = int'(ps);
            m_cfg = !legal(m_p);
            m_k = 0;
            c.ec = 5'd0;
            c.bc = 4'd0;
        end else if (m_cfg) begin
            c.ec = 5'd0;
            c.bc = 4'd0;
        end else begin
            m_k++;
            c.ec = 5'(m_k % m_p);
            c.bc = 4'(((m_k / m_p) > 15) ? 15 : (m_k / m_p));
        end
        c.cfg = m_cfg;
        c.rxs = hist[cyc - S + 1];
        cq.push_back(c);
        cyc++;
        mon_on = 1'b1;
    endtask

    // Idle gap then an enabled frame of len cycles. Each bit period holds a
    // random level, optionally with a one-cycle glitch inside the sample window.
    task automatic run_frame(input logic [5:0] ps, input int gap, input int len, input bit dse,
                             input bit glitchy, input bit directed, input bit ps_wiggle);
        int         p, h, n0, gpos, n, off;
        bit         bv, v0, v1, v2;
        smp_t       s;
        logic [5:0] ps2;
        logic [5:0] opts [4];
        opts = '{6'd8, 6'd16, 6'd32, 6'd4};
        p = int'(ps);
        h = p / 2;
        n0 = cyc + gap;
        bv = 1'b1;
        gpos = -1;
        for (int i = 0; i < gap; i++) hist[cyc + i] = 1'b1;
        for (int k = 0; k < len; k++) begin
            off = k % p;
            if (off == 0) begin
                bv = directed ? 1'b0 : 1'($urandom % 2);
                if (directed) gpos = h - 1 - S;
                else if (glitchy && ($urandom % 3 == 0)) gpos = h - 1 - S + int'($urandom % 3);
                else gpos = -1;
            end
            hist[n0 + k] = (off == gpos) ? ~bv : bv;
        end
        if (legal(p) && dse) begin
            for (int b = 0; b < 1000; b++) begin
                n = n0 + b * p + h + 1;
                if (n >= n0 + len) break;
                v0 = hist[n - 2 - S];
                v1 = hist[n - 1 - S];
                v2 = hist[n - S];
                s.val = (int'(v0) + int'(v1) + int'(v2)) >= 2;
                s.noise = !((v0 == v1) && (v1 == v2));
                s.ec = 5'(h + 2);
                s.bc = 4'((b > 15) ? 15 : b);
                sq.push_back(s);
            end
        end
        for (int i = 0; i < gap; i++) step(1'b1, 1'b0, dse, ps);
        for (int k = 0; k < len; k++) begin
            ps2 = (ps_wiggle && k > 2) ? opts[$urandom % 4] : ps;
            step(hist[n0 + k], 1'b1, dse, ps2);
        end
    endtask

    // Monitor: compare counters every cycle and vote results on each pulse.
    always @(posedge CLK) begin
        #2;
        if (mon_on) begin
            if (cq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL cnt_queue: got empty expected entry (t=%0t)", $time);
            end else begin
                mc = cq.pop_front();
                check("edge_cnt", 32'(edge_cnt), 32'(mc.ec));
                check("bit_cnt", 32'(bit_cnt), 32'(mc.bc));
                check("cfg_err", 32'(cfg_err), 32'(mc.cfg));
                check("rx_sync", 32'(rx_sync), 32'(mc.rxs));
            end
            if (sample_valid === 1'b1) begin
                if (sq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sample_valid: got unexpected pulse expected none (t=%0t)", $time);
                end else begin
                    ms = sq.pop_front();
                    last_bit = ms.val;
                    check("sampled_bit", 32'(sampled_bit), 32'(ms.val));
                    check("noise_det", 32'(noise_det), 32'(ms.noise));
                    check("sample_edge", 32'(edge_cnt), 32'(ms.ec));
                    check("sample_bit_cnt", 32'(bit_cnt), 32'(ms.bc));
                end
            end else begin
                check("noise_idle", 32'(noise_det), 32'd0);
                check("sampled_hold", 32'(sampled_bit), 32'(last_bit));
                check("valid_level", 32'(sample_valid), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 20000; i++) hist[i] = 1'b1;

        // Reset state.
        #1 RST = 1'b0;
        #2;
        check("rst_rx_sync", 32'(rx_sync), 32'd1);
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        check("rst_sampled_bit", 32'(sampled_bit), 32'd1);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_noise_det", 32'(noise_det), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // Directed scenarios.
        run_frame(6'd8, 2, 80, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(6'd16, 3, 16 * 6 + 5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(6'd8, 2, 8 * 4, 1'b1, 1'b0, 1'b1, 1'b0);
        run_frame(6'd8, 2, 300, 1'b1, 1'b1, 1'b0, 1'b0);
        run_frame(6'd8, 2, 3 * 8 + 5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(6'd16, 2, 16 * 4, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(6'd4, 2, 40, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(6'd12, 1, 40, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(6'd8, 1, 3 * 8 + 7, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(6'd32, 2, 32 * 3 + 20, 1'b0, 1'b1, 1'b0, 1'b0);

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            logic [5:0] opts [5];
            logic [5:0] ps;
            opts = '{6'd8, 6'd16, 6'd32, 6'd8, 6'd4};
            ps = opts[$urandom % 5];
            run_frame(ps, 1 + int'($urandom % 4), 10 + int'($urandom % 200),
                      ($urandom % 4) != 0, 1'b1, 1'b0, ($urandom % 3) == 0);
        end

        @(posedge CLK);
        #3;
        mon_on = 1'b0;
        check("leftover_samples", 32'(sq.size()), 32'd0);

        // Asynchronous reset in the middle of an active frame.
        @(negedge CLK);
        enable = 1'b0;
        Prescale = 6'd8;
        dat_samp_en = 1'b1;
        RX_IN = 1'b0;
        @(negedge CLK);
        enable = 1'b1;
        repeat (20) @(negedge CLK);
        #2;
        check("pre_rst_edge_cnt", 32'(edge_cnt), 32'd4);
        check("pre_rst_bit_cnt", 32'(bit_cnt), 32'd2);
        check("pre_rst_sampled_bit", 32'(sampled_bit), 32'd0);
        check("pre_rst_rx_sync", 32'(rx_sync), 32'd0);
        RST = 1'b0;
        #1;
        check("mid_rst_rx_sync", 32'(rx_sync), 32'd1);
        check("mid_rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("mid_rst_bit_cnt", 32'(bit_cnt), 32'd0);
        check("mid_rst_sampled_bit", 32'(sampled_bit), 32'd1);
        check("mid_rst_sample_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_noise_det", 32'(noise_det), 32'd0);
        check("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
        @(posedge CLK);
        #2;
        check("held_rst_edge_cnt", 32'(edge_cnt), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        // Enable is still high, so the reset ratio of 16 governs the count.
        repeat (16) @(posedge CLK);
        #2;
        check("post_rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("post_rst_bit_cnt", 32'(bit_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_edge_bit_sampler.md
Name: uart_rx_edge_bit_sampler

Overview:
Timing front end of the UART receiver. It synchronizes RX_IN and runs the oversampling edge counter and the bit counter. It also produces a majority-voted data bit for each bit period. It sits directly upstream of the RX control FSM, which consumes edge_cnt, bit_cnt and rx_sync and drives enable and dat_samp_en back into this block.

Parameters:
SYNC_STAGES, 2, number of flops in the RX_IN synchronizer (legal range 2..4)
CNT_W, 5, edge counter width; supports Prescale up to 2^CNT_W
BIT_W, 4, bit counter width

Ports:
CLK  in  1  system clock (oversampling clock, Prescale x baud)
RST  in  1  asynchronous, active-low reset
RX_IN  in  1  raw serial line, asynchronous to CLK
Prescale  in  6  oversampling ratio; legal values 8, 16, 32
enable  in  1  from FSM; counters run while high, clear while low
dat_samp_en  in  1  from FSM; enables the majority-vote sampler
rx_sync  out  1  synchronized RX_IN; the FSM uses this instead of raw RX_IN
edge_cnt  out  CNT_W  oversample position within the current bit, 0..Prescale-1
bit_cnt  out  BIT_W  index of the current bit in the frame; 0 = start bit
sampled_bit  out  1  majority-voted value of the current bit
sample_valid  out  1  one-cycle pulse when sampled_bit updates
noise_det  out  1  one-cycle pulse, coincident with sample_valid, when the three samples disagree
cfg_err  out  1  latched Prescale is illegal

Behaviour:
- Reset values: rx_sync=1, all synchronizer flops=1, edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0, noise_det=0, cfg_err=0, internal presc_q=16.
- Synchronizer: SYNC_STAGES-flop chain; rx_sync lags RX_IN by SYNC_STAGES cycles. It runs regardless of enable.
- Prescale latch: presc_q <= Prescale on every cycle where enable=0.
  - presc_q is frozen while enable=1; Prescale changes mid-frame are ignored until enable drops.
  - cfg_err <= 1 when the latched value is not 8, 16 or 32; otherwise cfg_err <= 0. Updated with presc_q.
- Counters when enable=0 or cfg_err=1: edge_cnt <= 0, bit_cnt <= 0.
- Counters when enable=1 and cfg_err=0:
  - If edge_cnt == presc_q-1: edge_cnt <= 0, and bit_cnt <= bit_cnt+1, saturating at 15 (no wrap).
  - Otherwise: edge_cnt <= edge_cnt+1.
  - The first cycle with enable=1 sees edge_cnt=0, bit_cnt=0.
- Sampler, with H = presc_q/2:
  - When dat_samp_en=1 and enable=1, capture rx_sync into s0 at edge_cnt==H-1 and into s1 at edge_cnt==H.
  - At edge_cnt==H+1, register sampled_bit <= majority(s0, s1, rx_sync).
  - In that same edge, pulse sample_valid=1 for one cycle; noise_det=1 if the three samples are not all equal.
  - Result: sampled_bit, sample_valid and noise_det are valid in the cycle where edge_cnt==H+2.
- When dat_samp_en=0: no captures, sample_valid=0, noise_det=0, sampled_bit holds its last value.
- Dropping enable mid-bit:
  - Counters clear on the next edge.
  - Partial s0/s1 captures are discarded, with no sample_valid.
  - sampled_bit holds its value.
- Simultaneous bit rollover and enable=0: clear wins; bit_cnt goes to 0, not +1.
- Asynchronous reset mid-frame returns every register to its reset value immediately.
- Outputs are all registered; no combinational path from any input to any output.

Test Plan:
- Prescale=8, enable held high for 80 cycles -> edge_cnt cycles 0..7; bit_cnt increments on each 7->0 wrap, reading 10 at cycle 80.
- Prescale=16, RX_IN=0 then 1 at bit boundaries, dat_samp_en=1 -> sample_valid pulses at edge_cnt==10 (H+2) of each bit; sampled_bit matches the driven bit value after SYNC_STAGES delay.
- Prescale=8, single-cycle 1-glitch on a 0 bit aligned to the first sample point -> sampled_bit=0, noise_det=1 together with sample_valid.
- enable high for 300 cycles at Prescale=8 -> bit_cnt saturates at 15, edge_cnt keeps wrapping.
- enable dropped at edge_cnt=5, bit_cnt=3 -> next cycle edge_cnt=0, bit_cnt=0, no sample_valid. Prescale changed 16->8 while enable=1 -> period stays 16 until enable drops.
- Prescale=4 latched -> cfg_err=1 and counters stuck at 0 with enable=1. Asserting RST low mid-frame -> all outputs at reset values within the same cycle.
